// File: rtl/mod_step_counter.sv
// Step counter: debounced push-button and gated auto tick each add one to a 4-bit count; also a free-running display refresh strobe.
// Press to step_pulse is 2 + DEBOUNCE_CYCLES + 1 clocks, count follows one clock later; no backpressure, every event is taken.
module mod_step_counter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REFRESH_DIV     = 4,
    parameter int AUTO_DIV        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_step,
    input  logic       auto_en,
    output logic [3:0] count,
    output logic       step_pulse,
    output logic       wrap,
    output logic       refresh_tick
);
    localparam int DCW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW  = $clog2(AUTO_DIV);
    localparam int RW  = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [1:0]     r_sync;
    logic [1:0]     r_sync_vld;
    logic           r_armed;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [DCW-1:0] r_dcnt;
    logic           w_dcnt_done;
    logic           w_fire;
    logic           w_btn_s;
    logic [AW-1:0]  r_acnt;
    logic           w_auto_tick;
    logic           w_inc;
    logic [RW-1:0]  r_rcnt;
    logic           r_step_pulse;
    logic           r_wrap;
    logic           r_refresh_tick;
    logic [3:0]     r_count;

    assign w_btn_s = r_sync[1];

    // A press held across reset must be released before it can count, so the
    // FSM is armed only after a genuine low sample has passed the synchronizer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync     <= '0;
            r_sync_vld <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], btn_step};
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            if (r_sync_vld[1] && !w_btn_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_dcnt_done = (r_dcnt == DCW'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_s && r_armed) begin
                    w_state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                end else if (w_dcnt_done) begin
                    w_state_nxt = PRESSED;
                    w_fire      = 1'b1;
                end
            end
            PRESSED: begin
                if (!w_btn_s) begin
                    w_state_nxt = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESSED;
                end else if (w_dcnt_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_dcnt       <= '0;
            r_step_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_step_pulse <= w_fire;
            if (w_state_nxt != r_state) begin
                r_dcnt <= '0;
            end else if (r_state == PRESS_WAIT || r_state == RELEASE_WAIT) begin
                r_dcnt <= r_dcnt + DCW'(1);
            end
        end
    end

    // The auto divider free-runs so toggling auto_en never shifts its phase.
    assign w_auto_tick = auto_en && (r_acnt == AW'(AUTO_DIV - 1));
    assign w_inc       = r_step_pulse || w_auto_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acnt  <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            if (r_acnt == AW'(AUTO_DIV - 1)) begin
                r_acnt <= '0;
            end else begin
                r_acnt <= r_acnt + AW'(1);
            end
            if (w_inc) begin
                r_count <= r_count + 4'd1;
            end
            r_wrap <= w_inc && (r_count == 4'hF);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rcnt         <= '0;
            r_refresh_tick <= 1'b0;
        end else begin
            if (r_rcnt == RW'(REFRESH_DIV - 1)) begin
                r_rcnt <= '0;
            end else begin
                r_rcnt <= r_rcnt + RW'(1);
            end
            r_refresh_tick <= (r_rcnt == RW'(REFRESH_DIV - 1));
        end
    end

    assign count        = r_count;
    assign step_pulse   = r_step_pulse;
    assign wrap         = r_wrap;
    assign refresh_tick = r_refresh_tick;

endmodule

// File: tb/tb_mod_step_counter.sv
// Bench for mod_step_counter: directed segment table, corner-case sequences and random stimulus against a run-length reference model.
module tb_mod_step_counter;
    localparam int DEB  = 4;
    localparam int RDIV = 4;
    localparam int ADIV = 8;
    localparam int NV   = 22;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_step;
    logic       auto_en;
    logic [3:0] count;
    logic       step_pulse;
    logic       wrap;
    logic       refresh_tick;

    int n_tests = 0;
    int n_fail  = 0;

    mod_step_counter #(
        .DEBOUNCE_CYCLES(DEB),
        .REFRESH_DIV    (RDIV),
        .AUTO_DIV       (ADIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_step    (btn_step),
        .auto_en     (auto_en),
        .count       (count),
        .step_pulse  (step_pulse),
        .wrap        (wrap),
        .refresh_tick(refresh_tick)
    );

    always #5 clk = ~clk;

    // Reference model: edges since reset, raw-button history, and a run length of
    // synchronized samples disagreeing with the accepted level.
    int m_e, m_run, m_count;
    bit m_r1, m_r2, m_pressed, m_armed, m_pulse, m_wrap, m_tick;

    typedef struct {
        logic btn;
        logic aen;
        int   ncyc;
        int   exp_pulses;
        int   exp_wraps;
        int   exp_count;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_e = 0; m_run = 0; m_count = 0;
        m_r1 = 0; m_r2 = 0; m_pressed = 0; m_armed = 0;
        m_pulse = 0; m_wrap = 0; m_tick = 0;
    endfunction

    function automatic void model_edge(input bit b, input bit a);
        int e;
        bit s, inc;
        e   = m_e + 1;
        inc = m_pulse || (a && (e % ADIV == 0));
        m_wrap = inc && (m_count == 15);
        if (inc) m_count = (m_count + 1) % 16;
        m_tick = (e % RDIV == 0);
        s = (e >= 3) ? m_r2 : 1'b0;
        m_pulse = 0;
        if (!m_pressed && !m_armed) begin
            m_run = 0;
        end else if (s != m_pressed) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_pressed = !m_pressed;
                m_run     = 0;
                m_pulse   = m_pressed;
            end
        end else begin
            m_run = 0;
        end
        if (e >= 3 && !s) m_armed = 1;
        m_r2 = m_r1;
        m_r1 = b;
        m_e  = e;
    endfunction

    task automatic run_cycle(input logic b, input logic a);
        btn_step = b;
        auto_en  = a;
        @(posedge clk);
        model_edge(b, a);
        #1;
        chk("model_count", int'(count), m_count);
        chk("model_step_pulse", int'(step_pulse), int'(m_pulse));
        chk("model_wrap", int'(wrap), int'(m_wrap));
        chk("model_refresh_tick", int'(refresh_tick), int'(m_tick));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        model_reset();
        chk("reset_count", int'(count), 0);
        chk("reset_step_pulse", int'(step_pulse), 0);
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_refresh_tick", int'(refresh_tick), 0);
        repeat (n) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at %0t, limit reached", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int np, nw, first_at, c7, c8, c120, c128, w128, nchg, prev, p119, c119, c120b, w120;
        int t [1:4];
        int runlen;
        bit rb, ra;

        btn_step = 1'b0;
        auto_en  = 1'b0;
        #2;

        // {btn, auto_en, cycles, pulses, wraps, count at end}
        vecs[0]  = '{1'b0, 1'b0,  4, 0, 0,  0};
        vecs[1]  = '{1'b1, 1'b0, 20, 1, 0,  1};
        vecs[2]  = '{1'b0, 1'b0, 20, 0, 0,  1};
        vecs[3]  = '{1'b1, 1'b0,  2, 0, 0,  1};
        vecs[4]  = '{1'b0, 1'b0,  2, 0, 0,  1};
        vecs[5]  = '{1'b1, 1'b0,  2, 0, 0,  1};
        vecs[6]  = '{1'b0, 1'b0,  2, 0, 0,  1};
        vecs[7]  = '{1'b1, 1'b0,  2, 0, 0,  1};
        vecs[8]  = '{1'b0, 1'b0,  2, 0, 0,  1};
        vecs[9]  = '{1'b1, 1'b0,  2, 0, 0,  1};
        vecs[10] = '{1'b0, 1'b0,  2, 0, 0,  1};
        vecs[11] = '{1'b1, 1'b0, 12, 1, 0,  2};
        vecs[12] = '{1'b0, 1'b0, 12, 0, 0,  2};
        vecs[13] = '{1'b1, 1'b0, 12, 1, 0,  3};
        vecs[14] = '{1'b0, 1'b0,  2, 0, 0,  3};
        vecs[15] = '{1'b1, 1'b0,  6, 0, 0,  3};
        vecs[16] = '{1'b0, 1'b0, 12, 0, 0,  3};
        vecs[17] = '{1'b0, 1'b1, 16, 0, 0,  5};
        vecs[18] = '{1'b1, 1'b1, 20, 1, 0,  9};
        vecs[19] = '{1'b0, 1'b1, 40, 0, 0, 14};
        vecs[20] = '{1'b0, 1'b1, 24, 0, 1,  1};
        vecs[21] = '{1'b0, 1'b0,  8, 0, 0,  1};

        do_reset(2);
        for (int v = 0; v < NV; v++) begin
            np = 0;
            nw = 0;
            for (int c = 0; c < vecs[v].ncyc; c++) begin
                run_cycle(vecs[v].btn, vecs[v].aen);
                np += int'(step_pulse);
                nw += int'(wrap);
            end
            chk($sformatf("vec%0d_pulses", v), np, vecs[v].exp_pulses);
            chk($sformatf("vec%0d_wraps", v), nw, vecs[v].exp_wraps);
            chk($sformatf("vec%0d_count", v), int'(count), vecs[v].exp_count);
        end

        // Clean press: pulse exactly 7 edges after the rise, count one edge later.
        do_reset(2);
        repeat (4) run_cycle(1'b0, 1'b0);
        np = 0; first_at = -1; c7 = -1; c8 = -1;
        for (int i = 1; i <= 20; i++) begin
            run_cycle(1'b1, 1'b0);
            if (step_pulse && first_at < 0) first_at = i;
            np += int'(step_pulse);
            if (i == 7) c7 = int'(count);
            if (i == 8) c8 = int'(count);
        end
        repeat (20) begin
            run_cycle(1'b0, 1'b0);
            np += int'(step_pulse);
        end
        chk("press_latency", first_at, 7);
        chk("press_count_at_pulse", c7, 0);
        chk("press_count_after", c8, 1);
        chk("press_pulse_total", np, 1);

        // Auto wrap over 128 edges from reset.
        auto_en = 1'b1;
        do_reset(2);
        nw = 0; nchg = 0; prev = 0; c7 = -1; c8 = -1; c120 = -1; c128 = -1; w128 = -1;
        for (int e = 1; e <= 128; e++) begin
            run_cycle(1'b0, 1'b1);
            nw += int'(wrap);
            if (int'(count) != prev) nchg++;
            prev = int'(count);
            if (e == 7)   c7 = int'(count);
            if (e == 8)   c8 = int'(count);
            if (e == 120) c120 = int'(count);
            if (e == 128) begin
                c128 = int'(count);
                w128 = int'(wrap);
            end
        end
        chk("auto_count_e7", c7, 0);
        chk("auto_count_e8", c8, 1);
        chk("auto_count_e120", c120, 15);
        chk("auto_count_e128", c128, 0);
        chk("auto_wrap_e128", w128, 1);
        chk("auto_wrap_total", nw, 1);
        chk("auto_count_changes", nchg, 16);

        // Coincidence: step_pulse sits on the auto tick that takes 14 to 15.
        do_reset(2);
        p119 = -1; c119 = -1; c120b = -1; w120 = -1;
        for (int e = 1; e <= 112; e++) run_cycle(1'b0, 1'b1);
        for (int e = 113; e <= 130; e++) begin
            run_cycle(1'b1, 1'b1);
            if (e == 119) begin
                p119 = int'(step_pulse);
                c119 = int'(count);
            end
            if (e == 120) begin
                c120b = int'(count);
                w120  = int'(wrap);
            end
        end
        chk("coin_pulse_e119", p119, 1);
        chk("coin_count_e119", c119, 14);
        chk("coin_count_e120", c120b, 15);
        chk("coin_wrap_e120", w120, 0);

        // Reset while PRESS_WAIT holds dcnt=2 and the button stays down.
        do_reset(2);
        repeat (4) run_cycle(1'b0, 1'b0);
        repeat (5) run_cycle(1'b1, 1'b0);
        do_reset(3);
        np = 0;
        for (int i = 1; i <= 30; i++) begin
            run_cycle(1'b1, 1'b0);
            np += int'(step_pulse);
            if (i <= 4) t[i] = int'(refresh_tick);
        end
        chk("midrst_no_pulse", np, 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_tick_e1", t[1], 0);
        chk("midrst_tick_e2", t[2], 0);
        chk("midrst_tick_e3", t[3], 0);
        chk("midrst_tick_e4", t[4], 1);
        np = 0;
        repeat (10) run_cycle(1'b0, 1'b0);
        repeat (12) begin
            run_cycle(1'b1, 1'b0);
            np += int'(step_pulse);
        end
        chk("midrst_repress_pulse", np, 1);
        chk("midrst_repress_count", int'(count), 1);

        // Random bouncing, auto_en toggling and occasional resets against the model.
        do_reset(2);
        rb = 0; ra = 0; runlen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (runlen == 0) begin
                rb     = 1'($urandom_range(0, 1));
                runlen = int'($urandom_range(1, 12));
            end
            runlen--;
            if ($urandom_range(0, 39) == 0) ra = !ra;
            if ($urandom_range(0, 599) == 0) do_reset(int'($urandom_range(1, 3)));
            run_cycle(rb, ra);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_step_counter.md
MOD_STEP_COUNTER -- requirements
Module: mod_step_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized cycles a level must hold to count as stable; legal values are 2 or more.
REQ-002 Parameter REFRESH_DIV, default 4: period in clk cycles of refresh_tick; legal values are 2 or more.
REQ-003 Parameter AUTO_DIV, default 8: period in clk cycles of the auto-increment tick; legal values are 2 or more.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as below.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 btn_step  input  1  raw, unsynchronized, bouncing push-button; high means pressed.
REQ-008 auto_en  input  1  free-run enable; sampled synchronously.
REQ-009 count  output  4  registered step count; feeds the seven-segment driver count input.
REQ-010 step_pulse  output  1  one-cycle pulse per debounced press.
REQ-011 wrap  output  1  one-cycle pulse when count goes from 15 to 0.
REQ-012 refresh_tick  output  1  one-cycle strobe every REFRESH_DIV cycles; digit-advance enable for the display.

Function
REQ-013 btn_step SHALL pass through a 2-flop synchronizer (btn_s) before any other logic uses it.
REQ-014 The debounce FSM SHALL have four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; it uses one cycle counter dcnt, cleared on every state change.
REQ-015 IDLE SHALL go to PRESS_WAIT when btn_s=1.
REQ-016 PRESS_WAIT SHALL return to IDLE if btn_s=0; if btn_s=1 and dcnt=DEBOUNCE_CYCLES-1, it SHALL go to PRESSED and assert step_pulse in the cycle after that edge, for exactly one cycle.
REQ-017 PRESSED SHALL go to RELEASE_WAIT when btn_s=0; holding the button SHALL never produce extra pulses.
REQ-018 RELEASE_WAIT SHALL return to PRESSED, with no pulse, if btn_s=1; if btn_s=0 and dcnt=DEBOUNCE_CYCLES-1, it SHALL go to IDLE.
REQ-019 The auto tick counter SHALL run 0..AUTO_DIV-1 continuously; auto_tick = auto_en AND (counter=AUTO_DIV-1); clearing auto_en does not reset the counter.
REQ-020 The increment condition inc = step_pulse OR auto_tick; count SHALL increase by exactly 1 on each clk edge where inc=1, including when both sources coincide.
REQ-021 count SHALL wrap modulo 16 (15 to 0); wrap SHALL be high in the cycle count shows 0 after an increment from 15, and low otherwise.
REQ-022 The refresh divider SHALL count 0..REFRESH_DIV-1 free-running; refresh_tick SHALL be a registered output high one cycle per period, independent of buttons and auto_en.
REQ-023 End-to-end press latency is 2 synchronizer cycles plus DEBOUNCE_CYCLES plus 1 cycle to step_pulse; count updates 1 cycle after step_pulse.

Reset
REQ-024 On reset=0, asynchronously: FSM=IDLE; dcnt, auto counter, refresh divider, synchronizer and count = 0; step_pulse, wrap, refresh_tick = 0.
REQ-025 Reset asserted mid-debounce or mid-press SHALL discard the pending press; after release the button must be seen low, then high and stable again, before a pulse.
REQ-026 The first refresh_tick after reset release SHALL occur REFRESH_DIV cycles after the first active clk edge.

Verification (DEBOUNCE_CYCLES=4, REFRESH_DIV=4, AUTO_DIV=8)
REQ-027 Clean press: btn_step high 20 cycles, then low 20 cycles -> exactly one step_pulse, 7 cycles after the rise (2+4+1); count goes from 0 to 1 one cycle later.
REQ-028 Bounce: toggle btn_step every 2 cycles for 16 cycles, then hold high -> no pulse during toggling; one pulse after the level has been stable 4 synchronized cycles.
REQ-029 Auto wrap: auto_en=1 for 128 cycles from reset -> count reaches 15 then 0; wrap is pulsed exactly once; count increments every 8 cycles.
REQ-030 Coincidence: time a press so step_pulse lands on the auto_tick cycle with count=14 -> count=15 (single increment), no wrap.
REQ-031 Reset mid-press: reset=0 for 3 cycles while PRESS_WAIT has dcnt=2, button still held -> no step_pulse until release and re-press; count=0; refresh_tick restarts per REQ-026.
